// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU bus controller.
// Holds the default parameter values, the fixed NMI window length and
// the access-type classification used by the wait-state logic.
package cpu_pkg;

   localparam int unsigned DEF_DIV_W      = 4;
   localparam int unsigned DEF_WS_W       = 2;
   localparam int unsigned DEF_INT_PERIOD = 69888;
   localparam int unsigned DEF_INT_LEN    = 32;

   // nmi_n stays asserted for this many CPU cycles
   localparam int unsigned NMI_CEPS = 16;

   typedef enum logic [1:0] {
      ACC_NONE,
      ACC_MEM,
      ACC_IO,
      ACC_ACK
   } acc_e;

endpackage

// File: rtl/cpu_clkdiv.sv
// CPU clock-enable generator.
// Phase counter runs 0..div and wraps; one cep pulse per CPU cycle at
// phase 0 and one cen pulse at phase (div+1)>>1. div is captured only at
// the wrap so a cycle in progress is never shortened; div==0 acts as 1.
// Ports:
//   clock  system clock
//   reset  synchronous, active-low
//   div    CPU cycle length minus one, in clocks
//   cep    positive-phase clock enable (one clock wide)
//   cen    negative-phase clock enable (one clock wide)
module cpu_clkdiv
   import cpu_pkg::*;
#(
   parameter int unsigned DIV_W = DEF_DIV_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [DIV_W-1:0] div,
   output logic             cep,
   output logic             cen
);

   logic [DIV_W-1:0] pc_q, pc_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             cep_q, cep_d;
   logic             cen_q, cen_d;
   logic [DIV_W-1:0] div_eff;
   logic [DIV_W-1:0] half;
   logic             wrap;

   always_comb begin
      div_eff = (div == '0) ? DIV_W'(1) : div;
      // (div_q + 1) >> 1 without needing an extra bit
      half    = (div_q >> 1) + {{(DIV_W-1){1'b0}}, div_q[0]};
      wrap    = (pc_q == div_q);
      pc_d    = wrap ? '0 : pc_q + DIV_W'(1);
      div_d   = wrap ? div_eff : div_q;
      // enables are registered, so they trail pc by one clock; this puts
      // the first cep on the first clock after reset release
      cep_d   = (pc_q == '0);
      cen_d   = (pc_q == half);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         pc_q  <= '0;
         div_q <= div_eff;
         cep_q <= 1'b0;
         cen_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         div_q <= div_d;
         cep_q <= cep_d;
         cen_q <= cen_d;
      end
   end

   assign cep = cep_q;
   assign cen = cen_q;

endmodule

// File: rtl/cpu_ctl.sv
// CPU bus controller: clock enables, wait-state insertion, periodic
// maskable interrupt and NMI pulse shaping.
// Ports:
//   clock, reset      single clock, synchronous active-low reset
//   div               CPU cycle length minus one (clocks)
//   mreq/iorq/rfsh/m1 CPU bus strobes, active-low
//   ws_mem, ws_io     wait states per memory / I/O access
//   int_en            periodic interrupt enable
//   nmi_req           NMI request, active-high level
//   cep, cen          clock enables
//   wait_n            CPU wait, active-low
//   int_n, nmi_n      CPU interrupts, active-low
module cpu_ctl
   import cpu_pkg::*;
#(
   parameter int unsigned DIV_W      = DEF_DIV_W,
   parameter int unsigned WS_W       = DEF_WS_W,
   parameter int unsigned INT_PERIOD = DEF_INT_PERIOD,
   parameter int unsigned INT_LEN    = DEF_INT_LEN
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [DIV_W-1:0] div,
   input  logic             mreq,
   input  logic             iorq,
   input  logic             rfsh,
   input  logic             m1,
   input  logic [WS_W-1:0]  ws_mem,
   input  logic [WS_W-1:0]  ws_io,
   input  logic             int_en,
   input  logic             nmi_req,
   output logic             cep,
   output logic             cen,
   output logic             wait_n,
   output logic             int_n,
   output logic             nmi_n
);

   localparam int unsigned IC_W  = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;
   localparam int unsigned LEN_W = $clog2(INT_LEN + 1);
   localparam int unsigned NMI_W = $clog2(NMI_CEPS + 1);

   cpu_clkdiv #(.DIV_W(DIV_W)) u_clkdiv (
      .clock (clock),
      .reset (reset),
      .div   (div),
      .cep   (cep),
      .cen   (cen)
   );

   logic             mreq_prev_q, mreq_prev_d;
   logic             iorq_prev_q, iorq_prev_d;
   logic [WS_W-1:0]  wc_q, wc_d;
   logic [IC_W-1:0]  ic_q, ic_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic             nmi_prev_q, nmi_prev_d;
   logic             nmi_pend_q, nmi_pend_d;
   logic [NMI_W-1:0] nmi_cnt_q, nmi_cnt_d;

   acc_e acc;
   logic ack;
   logic int_wrap;
   logic nmi_rise;
   logic nmi_busy;

   always_comb begin
      // access classification, sampled on cep; memory wins over I/O
      acc = ACC_NONE;
      if (cep) begin
         if (!mreq && rfsh && mreq_prev_q) begin
            acc = ACC_MEM;
         end else if (!iorq && iorq_prev_q) begin
            acc = m1 ? ACC_IO : ACC_ACK;
         end
      end
      mreq_prev_d = cep ? mreq : mreq_prev_q;
      iorq_prev_d = cep ? iorq : iorq_prev_q;

      wc_d = wc_q;
      if (acc == ACC_MEM) begin
         wc_d = ws_mem;
      end else if (acc == ACC_IO) begin
         wc_d = ws_io;
      end else if (cen && (wc_q != '0)) begin
         wc_d = wc_q - WS_W'(1);
      end

      // periodic interrupt; a wrap outranks a simultaneous acknowledge
      ack      = cep && !m1 && !iorq;
      int_wrap = cep && (ic_q == IC_W'(INT_PERIOD - 1));
      ic_d     = ic_q;
      if (cep) begin
         ic_d = int_wrap ? '0 : ic_q + IC_W'(1);
      end
      len_d = len_q;
      if (int_wrap && int_en) begin
         len_d = LEN_W'(INT_LEN);
      end else if (!int_en || ack) begin
         len_d = '0;
      end else if (cep && (len_q != '0)) begin
         len_d = len_q - LEN_W'(1);
      end

      // NMI: a rising edge arms a pending start; edges while pending or
      // active are dropped
      nmi_prev_d = nmi_req;
      nmi_rise   = nmi_req && !nmi_prev_q;
      nmi_busy   = nmi_pend_q || (nmi_cnt_q != '0);
      nmi_pend_d = nmi_pend_q;
      nmi_cnt_d  = nmi_cnt_q;
      if (cep && nmi_pend_q) begin
         nmi_pend_d = 1'b0;
         nmi_cnt_d  = NMI_W'(NMI_CEPS);
      end else if (cep && (nmi_cnt_q != '0)) begin
         nmi_cnt_d = nmi_cnt_q - NMI_W'(1);
      end
      if (nmi_rise && !nmi_busy) begin
         nmi_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         mreq_prev_q <= 1'b1;
         iorq_prev_q <= 1'b1;
         wc_q        <= '0;
         ic_q        <= '0;
         len_q       <= '0;
         nmi_prev_q  <= 1'b1;
         nmi_pend_q  <= 1'b0;
         nmi_cnt_q   <= '0;
      end else begin
         mreq_prev_q <= mreq_prev_d;
         iorq_prev_q <= iorq_prev_d;
         wc_q        <= wc_d;
         ic_q        <= ic_d;
         len_q       <= len_d;
         nmi_prev_q  <= nmi_prev_d;
         nmi_pend_q  <= nmi_pend_d;
         nmi_cnt_q   <= nmi_cnt_d;
      end
   end

   assign wait_n = (wc_q == '0);
   assign int_n  = (len_q == '0);
   assign nmi_n  = (nmi_cnt_q == '0);

endmodule

// File: doc/cpu_ctl.md
CPU_CTL -- requirements
Module: cpu_ctl

Interface
REQ-001 Parameter DIV_W, default 4: width of the clock-divider select.
REQ-002 Parameter WS_W, default 2: width of the wait-state counts.
REQ-003 Parameter INT_PERIOD, default 69888: CPU cycles between maskable interrupts.
REQ-004 Parameter INT_LEN, default 32: maximum interrupt assertion length, in CPU cycles.
REQ-005 Port list (one clock; reset is synchronous and active-low):
- clock  in  1  system clock, the single clock of the block.
- reset  in  1  synchronous, active-low reset.
- div  in  DIV_W  CPU cycle length minus one, in clock ticks; legal range 1..2^DIV_W-1.
- mreq  in  1  CPU memory request, active-low.
- iorq  in  1  CPU I/O request, active-low.
- rfsh  in  1  CPU refresh, active-low.
- m1  in  1  CPU opcode fetch / acknowledge, active-low.
- ws_mem  in  WS_W  wait states to insert per memory access.
- ws_io  in  WS_W  wait states to insert per I/O access.
- int_en  in  1  enables the periodic interrupt.
- nmi_req  in  1  NMI request, active-high level.
- cep  out  1  positive-phase clock enable.
- cen  out  1  negative-phase clock enable.
- wait_n  out  1  CPU wait, active-low.
- int_n  out  1  CPU maskable interrupt, active-low.
- nmi_n  out  1  CPU non-maskable interrupt, active-low.

Function
REQ-006 Phase counter pc SHALL count 0..div and wrap to 0, advancing one step per clock.
REQ-007 cep SHALL be 1 for exactly one clock when pc==0; cen SHALL be 1 for exactly one clock when pc==(div+1)>>1.
REQ-008 A new div value SHALL be sampled only at wrap, so no CPU cycle is ever shortened or split.
REQ-009 div==0 SHALL be treated as div==1.
REQ-010 Access detect:
- On a cep where mreq is low, rfsh is high and mreq was high on the previous cep, wait counter wc SHALL load ws_mem.
- An iorq falling edge sampled the same way SHALL load ws_io, unless m1 is low (interrupt acknowledge).
- If both edges occur on the same cep, mreq wins.
REQ-011 wait_n SHALL be 0 while wc!=0; wc SHALL decrement on each cen.
REQ-012 A zero count SHALL insert no wait state; refresh cycles SHALL never be stretched.
REQ-013 The interrupt counter ic SHALL count cep pulses 0..INT_PERIOD-1 and wrap; it SHALL run regardless of int_en.
REQ-014 At the wrap, with int_en high, int_n SHALL go low and a length counter SHALL load INT_LEN.
REQ-015 int_n SHALL return high at the first of:
- the length counter reaching 0, decremented on cep;
- an acknowledge, i.e. m1 and iorq both low on a cep;
- int_en going low.
REQ-016 If an acknowledge and a new wrap coincide, the wrap SHALL win (int_n stays low, length reloads).
REQ-017 nmi_n SHALL go low on the cep after a rising edge of nmi_req and stay low for exactly 16 cep pulses.
REQ-018 A further nmi_req rising edge during those 16 cep pulses SHALL be ignored.

Reset
REQ-019 While reset is low at a clock edge, the block SHALL take its reset state:
- pc, wc, ic and the length counter = 0; stored edge history = inactive (high);
- cep = 0, cen = 0, wait_n = 1, int_n = 1, nmi_n = 1.
REQ-020 First cep SHALL occur on the first clock after reset is released.
REQ-021 Reset mid-access or mid-interrupt SHALL abort the operation with no residual pulse afterwards.

Structure
REQ-022 Shared package cpu_pkg SHALL hold DIV_W, WS_W, INT_PERIOD and INT_LEN defaults and an access-type enum {ACC_NONE, ACC_MEM, ACC_IO, ACC_ACK}.
REQ-023 Sub-module cpu_clkdiv SHALL implement pc, cep and cen (REQ-006..009); all other logic SHALL live in cpu_ctl.

Verification
REQ-024 Bench SHALL cover the following scenarios:
- div=3 -> cep every 4 clocks at pc=0, cen at pc=2; change div to 7 mid-cycle -> current cycle completes at 4, then 8-clock cycles.
- ws_mem=2, mreq falls with rfsh high -> wait_n low for exactly 2 cen pulses; same access with rfsh low -> wait_n stays 1.
- ws_io=3 with iorq and m1 both low -> no wait; iorq alone -> 3 wait cen pulses.
- INT_PERIOD=100, INT_LEN=32, no acknowledge -> int_n low 32 ceps every 100 ceps; acknowledge at cep 5 -> int_n high on the next clock.
- nmi_req pulses twice 4 ceps apart -> single nmi_n low window of 16 ceps.
- reset asserted with wait_n and int_n low -> all outputs at reset values on the next clock, first cep one clock after release.
